// File: rtl/serial_add_seq.sv
// Bit-serial adder sequencer driving an external single-bit full adder cell, LSB first.
// Optional build macro SERIAL_ADD_SUB_EN adds sub_in for two's-complement subtraction.
module serial_add_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub_in,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_c,
  input  logic             fa_s,
  input  logic             fa_carry
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic [WIDTH-1:0] sum_out_q, sum_out_d;
  logic             cout_q, cout_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sub_q;
  logic             sub_d;
  logic             load_sub;

`ifdef SERIAL_ADD_SUB_EN
  assign load_sub = sub_in;
`else
  assign load_sub = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    sum_sh_d  = sum_sh_q;
    sum_out_d = sum_out_q;
    cout_d    = cout_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    sub_d     = sub_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    fa_a      = 1'b0;
    fa_b      = 1'b0;
    fa_c      = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = rst_n;
        if (in_valid && rst_n) begin
          a_sh_d  = a_in;
          b_sh_d  = b_in;
          sub_d   = load_sub;
          carry_d = load_sub ? 1'b1 : cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        fa_a     = a_sh_q[0];
        fa_b     = b_sh_q[0] ^ sub_q;
        fa_c     = carry_q;
        sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};
        carry_d  = fa_carry;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        // Output registers load only on the final bit so sum_out/cout_out stay put during RUN.
        if (cnt_q == CNT_LAST) begin
          sum_out_d = {fa_s, sum_sh_q[WIDTH-1:1]};
          cout_d    = fa_carry;
          cnt_d     = '0;
          state_d   = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      sum_sh_q  <= '0;
      sum_out_q <= '0;
      cout_q    <= 1'b0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      sub_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      sum_sh_q  <= sum_sh_d;
      sum_out_q <= sum_out_d;
      cout_q    <= cout_d;
      carry_q   <= carry_d;
      cnt_q     <= cnt_d;
      sub_q     <= sub_d;
    end
  end

  assign sum_out  = sum_out_q;
  assign cout_out = cout_q;

endmodule

// File: tb/tb_serial_add_seq.sv
// Directed bench for serial_add_seq (WIDTH=8) with a combinational full adder cell model.
module tb_serial_add_seq;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
  logic         sub_in = 1'b0;
`endif
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum_out;
  logic         cout_out;
  logic         fa_a, fa_b, fa_c, fa_s, fa_carry;

  int vectors = 0;
  int miscompares = 0;

  serial_add_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .cin(cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub_in(sub_in),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .sum_out(sum_out), .cout_out(cout_out),
    .fa_a(fa_a), .fa_b(fa_b), .fa_c(fa_c),
    .fa_s(fa_s), .fa_carry(fa_carry)
  );

  always #5 clk = ~clk;

  assign fa_s     = fa_a ^ fa_b ^ fa_c;
  assign fa_carry = (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Leaves the caller at the first falling edge after the accepting edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int wt;
    @(negedge clk);
    a_in = a; b_in = b; cin = c; in_valid = 1'b1;
    wt = 0;
    while (!in_ready && wt < 30) begin
      @(negedge clk);
      wt++;
    end
    chk("accept_wait", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic [W-1:0] es, input logic ec);
    int lat;
    start_op(a, b, c);
    wait_done(lat);
    chk({tag, "_latency"}, 64'(lat), 64'd8);
    chk({tag, "_sum"}, 64'(sum_out), 64'(es));
    chk({tag, "_cout"}, {63'd0, cout_out}, {63'd0, ec});
    out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_release"}, {63'd0, out_valid}, 64'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int cyc;
    int accepted;
    int last_acc;
    bit pending;
    logic [W:0] q[$];
    logic [W:0] e;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_sum", 64'(sum_out), 64'd0);
    chk("rst_cout", {63'd0, cout_out}, 64'd0);
    chk("rst_fa", {61'd0, fa_a, fa_b, fa_c}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", {63'd0, in_ready}, 64'd1);

    // Basic adds and carry boundaries
    run_op("t1", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);
    run_op("t2a", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_op("t2b", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);

    // Back-pressure in DONE with ignored in_valid pulses
    start_op(8'h12, 8'h34, 1'b0);
    wait_done(lat);
    chk("t3_latency", 64'(lat), 64'd8);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      a_in = 8'($urandom());
      b_in = 8'($urandom());
      @(negedge clk);
      chk("t3_hold_valid", {63'd0, out_valid}, 64'd1);
      chk("t3_hold_sum", 64'(sum_out), 64'h46);
      chk("t3_hold_cout", {63'd0, cout_out}, 64'd0);
      chk("t3_in_ready", {63'd0, in_ready}, 64'd0);
      chk("t3_fa_idle", {61'd0, fa_a, fa_b, fa_c}, 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("t3_release", {63'd0, out_valid}, 64'd0);
    chk("t3_ready_back", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b0;

    // Reset in the middle of RUN
    start_op(8'h77, 8'h11, 1'b1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("t4_rst_ready", {63'd0, in_ready}, 64'd0);
    chk("t4_rst_fa", {61'd0, fa_a, fa_b, fa_c}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t4_ready_after", {63'd0, in_ready}, 64'd1);
    chk("t4_valid_after", {63'd0, out_valid}, 64'd0);
    run_op("t4_next", 8'h33, 8'h44, 1'b0, 8'h77, 1'b0);

    // Streaming with out_ready tied high
    out_ready = 1'b1;
    a_in = 8'($urandom()); b_in = 8'($urandom()); cin = 1'($urandom());
    in_valid = 1'b1;
    cyc = 0; accepted = 0; last_acc = -1; pending = 1'b0;
    while ((accepted < 1000 || q.size() > 0) && cyc < 12000) begin
      if (out_valid) begin
        if (q.size() > 0) begin
          chk("t5_sum", 64'(sum_out), 64'(q[0][W-1:0]));
          chk("t5_cout", {63'd0, cout_out}, {63'd0, q[0][W]});
          void'(q.pop_front());
        end else begin
          chk("t5_spurious_out", {63'd0, out_valid}, 64'd0);
        end
      end
      if (in_ready && in_valid) begin
        if (last_acc >= 0) chk("t5_spacing", 64'(cyc - last_acc), 64'd10);
        last_acc = cyc;
        e = {1'b0, a_in} + {1'b0, b_in} + {{W{1'b0}}, cin};
        q.push_back(e);
        accepted++;
        pending = 1'b1;
      end
      @(negedge clk);
      cyc++;
      if (pending) begin
        pending = 1'b0;
        if (accepted >= 1000) in_valid = 1'b0;
        else begin
          a_in = 8'($urandom()); b_in = 8'($urandom()); cin = 1'($urandom());
        end
      end
    end
    chk("t5_accepted", 64'(accepted), 64'd1000);
    chk("t5_drained", 64'(q.size()), 64'd0);
    out_ready = 1'b0;

`ifdef SERIAL_ADD_SUB_EN
    // Subtraction; cin is ignored
    sub_in = 1'b1;
    run_op("t6a", 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0);
    run_op("t6b", 8'h07, 8'h05, 1'b1, 8'h02, 1'b1);
    sub_in = 1'b0;
    run_op("t6c", 8'h07, 8'h05, 1'b0, 8'h0C, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
